output_register_tx: RTL and testbench

OUTPUT_REGISTER_TX -- requirements
Module: output_register_tx

---
 rtl/output_register_tx.sv | 137 +++++++++++++
 tb/tb_output_register_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_register_tx.sv
// CPU output register feeding an 8N1 serial transmitter.
// An OUT strobe is accepted only while fgo=1; an OUT strobe while fgo=0 raises the sticky ovr_err.
module output_register_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_outr,
    input  logic [15:0] in_data,
    input  logic        clr_err,
    output logic        fgo,
    output logic [7:0]  outr_data,
    output logic        txd,
    output logic        busy,
    output logic        ovr_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       outr_q, outr_d;
    logic             fgo_q, fgo_d;
    logic             txd_q, txd_d;
    logic             ovr_q, ovr_d;
    logic             lastCycle;
    logic             unusedBusBits;

    // Only the low byte of the bus carries a character.
    assign unusedBusBits = ^in_data[15:8];

    assign lastCycle = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= 3'd0;
            outr_q   <= 8'h00;
            fgo_q    <= 1'b1;
            txd_q    <= 1'b1;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            outr_q   <= outr_d;
            fgo_q    <= fgo_d;
            txd_q    <= txd_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        outr_d   = outr_q;
        fgo_d    = fgo_q;
        txd_d    = txd_q;
        ovr_d    = ovr_q;

        // A rejected load outranks a simultaneous clear.
        if (load_outr && !fgo_q) begin
            ovr_d = 1'b1;
        end else if (clr_err) begin
            ovr_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (load_outr && fgo_q) begin
                    outr_d   = in_data[7:0];
                    fgo_d    = 1'b0;
                    state_d  = START;
                    txd_d    = 1'b0;
                    cnt_d    = '0;
                    bitIdx_d = 3'd0;
                end
            end
            START: begin
                if (lastCycle) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    txd_d   = outr_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (lastCycle) begin
                    cnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        bitIdx_d = 3'd0;
                        state_d  = STOP;
                        txd_d    = 1'b1;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        txd_d    = outr_q[bitIdx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // fgo rises on the same edge that returns to IDLE, so a load on this edge is still rejected.
                if (lastCycle) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    fgo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fgo       = fgo_q;
    assign outr_data = outr_q;
    assign txd       = txd_q;
    assign busy      = (state_q != IDLE);
    assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_output_register_tx.sv
// Scoreboard bench for output_register_tx: the stimulus side models the register and flag behaviour
// and queues the expected characters, while a serial monitor decodes frames from txd and checks them.
module tb_output_register_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk;
    logic        rst;
    logic        load_outr;
    logic [15:0] in_data;
    logic        clr_err;
    logic        fgo;
    logic [7:0]  outr_data;
    logic        txd;
    logic        busy;
    logic        ovr_err;

    output_register_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_outr (load_outr),
        .in_data   (in_data),
        .clr_err   (clr_err),
        .fgo       (fgo),
        .outr_data (outr_data),
        .txd       (txd),
        .busy      (busy),
        .ovr_err   (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checkCount = 0;
    int         errorCount = 0;
    logic [7:0] expQ[$];
    int         frameStarts[$];

    // Reference model: a frame is simply a countdown of FRAME edges during which fgo is low.
    bit         mFgo;
    bit         mOvr;
    logic [7:0] mOutr;
    int         mRemain;

    task automatic checkValue(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mFgo    = 1'b1;
        mOvr    = 1'b0;
        mOutr   = 8'h00;
        mRemain = 0;
        expQ.delete();
    endtask

    task automatic modelEdge(input logic ld, input logic [15:0] d, input logic clr);
        bit preFgo;
        preFgo = mFgo;
        if (!preFgo) begin
            mRemain--;
            if (mRemain == 0) mFgo = 1'b1;
        end
        if (ld && preFgo) begin
            mOutr   = d[7:0];
            mFgo    = 1'b0;
            mRemain = FRAME;
            expQ.push_back(d[7:0]);
        end
        if (ld && !preFgo) mOvr = 1'b1;
        else if (clr)      mOvr = 1'b0;
    endtask

    task automatic checkOutput();
        checkValue("fgo", 16'(fgo), 16'(mFgo));
        checkValue("busy", 16'(busy), 16'(!mFgo));
        checkValue("outr_data", 16'(outr_data), 16'(mOutr));
        checkValue("ovr_err", 16'(ovr_err), 16'(mOvr));
        if (mFgo) checkValue("txdIdle", 16'(txd), 16'd1);
    endtask

    // Called just after a falling edge; drives one clock cycle of inputs.
    task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic clr);
        load_outr = ld;
        in_data   = d;
        clr_err   = clr;
        @(posedge clk);
        modelEdge(ld, d, clr);
        @(negedge clk);
        checkOutput();
        #1;
        load_outr = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (!mFgo && guard < 2 * FRAME) begin
            idle(1);
            guard++;
        end
        if (!mFgo) checkValue("waitIdleTimeout", 16'd0, 16'd1);
    endtask

    // Serial monitor: collects FRAME samples from the start bit and compares against the queue.
    logic txSamples[FRAME];
    int   nStored  = 0;
    bit   inFrame  = 1'b0;
    int   sampleNum = 0;

    task automatic checkFrame();
        logic [7:0] got;
        bit         shapeOk;
        shapeOk = 1'b1;
        for (int b = 0; b < 10; b++)
            for (int s = 0; s < CPB; s++)
                if (txSamples[b*CPB+s] !== txSamples[b*CPB]) shapeOk = 1'b0;
        checkValue("bitHold", 16'(shapeOk), 16'd1);
        checkValue("startBit", 16'(txSamples[0]), 16'd0);
        checkValue("stopBit", 16'(txSamples[9*CPB]), 16'd1);
        for (int i = 0; i < 8; i++) got[i] = txSamples[(i+1)*CPB];
        if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpectedFrame: got %0h, expected no frame at %0t", got, $time);
        end else begin
            checkValue("frameData", 16'(got), 16'(expQ.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        sampleNum++;
        if (rst) begin
            inFrame = 1'b0;
            nStored = 0;
        end else if (!inFrame) begin
            if (txd === 1'b0) begin
                inFrame      = 1'b1;
                txSamples[0] = txd;
                nStored      = 1;
                frameStarts.push_back(sampleNum);
            end
        end else if (nStored < FRAME) begin
            txSamples[nStored] = txd;
            nStored++;
            if (nStored == FRAME) begin
                checkValue("fgoLowInStop", 16'(fgo), 16'd0);
                checkFrame();
            end
        end else begin
            checkValue("fgoRiseLatency", 16'(fgo), 16'd1);
            inFrame = 1'b0;
            nStored = 0;
        end
    end

    initial begin
        logic ld;
        logic clr;
        rst       = 1'b1;
        load_outr = 1'b0;
        clr_err   = 1'b0;
        in_data   = 16'h0000;
        modelReset();
        repeat (3) @(negedge clk);
        #1;
        checkOutput();
        checkValue("resetTxd", 16'(txd), 16'd1);
        rst = 1'b0;
        idle(2);

        // First frame, overrun mid-frame, clear, then a load on the edge where fgo rises.
        applyStimulus(1'b1, 16'h12A5, 1'b0);
        checkValue("loadA5", 16'(outr_data), 16'h00A5);
        idle(9);
        applyStimulus(1'b1, 16'h003C, 1'b0);
        checkValue("overrunSet", 16'(ovr_err), 16'd1);
        checkValue("outrHeld", 16'(outr_data), 16'h00A5);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkValue("overrunClr", 16'(ovr_err), 16'd0);
        idle(28);
        checkValue("fgoStillLow", 16'(fgo), 16'd0);
        applyStimulus(1'b1, 16'h0077, 1'b0);
        checkValue("edgeLoadRejected", 16'(ovr_err), 16'd1);
        checkValue("fgoRoseOnTime", 16'(fgo), 16'd1);
        checkValue("outrAfterReject", 16'(outr_data), 16'h00A5);
        applyStimulus(1'b1, 16'h00C3, 1'b0);
        checkValue("loadAfterRise", 16'(outr_data), 16'h00C3);

        // Asynchronous reset in the middle of data bit 3, with a load held during reset.
        idle(17);
        #1;
        rst       = 1'b1;
        load_outr = 1'b1;
        in_data   = 16'h00FF;
        #1;
        checkValue("asyncRstTxd", 16'(txd), 16'd1);
        checkValue("asyncRstFgo", 16'(fgo), 16'd1);
        checkValue("asyncRstBusy", 16'(busy), 16'd0);
        modelReset();
        @(negedge clk);
        checkOutput();
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 16'hABFF, 1'b0);
        checkValue("loadAfterRst", 16'(outr_data), 16'h00FF);
        waitIdle();

        // Back-to-back frames, each loaded on the first edge with fgo=1.
        applyStimulus(1'b1, 16'h5500, 1'b0);
        idle(FRAME);
        applyStimulus(1'b1, 16'h0080, 1'b0);
        checkValue("backToBackLoad", 16'(outr_data), 16'h0080);
        waitIdle();
        idle(2);
        checkValue("frameGap", 16'(frameStarts[$] - frameStarts[$-1]), 16'(FRAME + 1));

        // Random traffic, biased to load soon after fgo rises.
        repeat (1500) begin
            ld  = ($urandom_range(0, 15) == 0) || (mFgo && $urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 31) == 0);
            applyStimulus(ld, 16'($urandom), clr);
        end
        waitIdle();
        idle(3);
        checkValue("queueDrained", 16'(expQ.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
